// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token code words, their {C1,C0} encoding,
// and the word-aligner state type.
package tmds_pkg;

    // Control-token symbols as seen on the wire, bit 0 transmitted first.
    localparam logic [9:0] TMDS_CTL0 = 10'h354;
    localparam logic [9:0] TMDS_CTL1 = 10'h0AB;
    localparam logic [9:0] TMDS_CTL2 = 10'h154;
    localparam logic [9:0] TMDS_CTL3 = 10'h2AB;

    // {C1,C0} carried by each token.
    localparam logic [1:0] CTL_CODE0 = 2'b00;
    localparam logic [1:0] CTL_CODE1 = 2'b01;
    localparam logic [1:0] CTL_CODE2 = 2'b10;
    localparam logic [1:0] CTL_CODE3 = 2'b11;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } align_state_e;

    // Bit offsets cycle 0..9 so the hunt covers every possible boundary.
    function automatic logic [3:0] next_offset(input logic [3:0] offset);
        return (offset == 4'd9) ? 4'd0 : offset + 4'd1;
    endfunction

endpackage

// File: rtl/tmds_token_detect.sv
// Combinational TMDS control-token recogniser; shared by the word aligner
// and the TMDS decoder.
module tmds_token_detect
    import tmds_pkg::*;
(
    input  logic [9:0] word,
    output logic       is_tok,
    output logic [1:0] ctl
);

    always_comb begin
        // NOTE: both outputs get a default before the case so no path leaves
        // them unassigned, which would otherwise infer a latch.
        is_tok = 1'b1;
        ctl    = CTL_CODE0;
        case (word)
            TMDS_CTL0: ctl = CTL_CODE0;
            TMDS_CTL1: ctl = CTL_CODE1;
            TMDS_CTL2: ctl = CTL_CODE2;
            TMDS_CTL3: ctl = CTL_CODE3;
            default:   is_tok = 1'b0;
        endcase
    end

endmodule

// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner: barrel-shifts deserializer words until the
// control tokens line up, then holds that offset while tokens keep arriving.
module tmds_word_aligner
    import tmds_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic       ref_clk_i,
    input  logic       rst,
    input  logic [9:0] raw_i,
    output logic [9:0] dat_o,
    output logic       tok_o,
    output logic [1:0] ctl_o,
    output logic       locked_o,
    output logic [3:0] offset_o
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [9:0]    prev_q;
    logic [19:0]   pair;
    logic [9:0]    w;
    logic          is_tok;
    logic [1:0]    ctl;
    align_state_e  state;
    logic [TW-1:0] timer;
    logic [7:0]    tok_cnt;
    logic [8:0]    cnt_next;
    logic          timer_done;

    // The previous word supplies the earlier bits of any window that
    // straddles a deserializer word boundary.
    assign pair = {raw_i, prev_q} >> offset_o;
    assign w    = pair[9:0];

    tmds_token_detect u_detect (
        .word   (w),
        .is_tok (is_tok),
        .ctl    (ctl)
    );

    assign cnt_next   = {1'b0, tok_cnt} + 9'd1;
    assign timer_done = (timer == TW'(TIMEOUT - 1));

    always_ff @(posedge ref_clk_i or posedge rst) begin
        // NOTE: registers are updated with non-blocking assignments so every
        // flop samples the pre-edge values regardless of statement order.
        if (rst) begin
            prev_q <= '0;
            dat_o  <= '0;
            tok_o  <= 1'b0;
            ctl_o  <= '0;
        end else begin
            prev_q <= raw_i;
            dat_o  <= w;
            tok_o  <= is_tok;
            if (is_tok) begin
                ctl_o <= ctl;
            end
        end
    end

    // A token always wins over an expiring timer, in both states.
    always_ff @(posedge ref_clk_i or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            offset_o <= '0;
            locked_o <= 1'b0;
            timer    <= '0;
            tok_cnt  <= '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (is_tok) begin
                        timer <= '0;
                        if (cnt_next == 9'(LOCK_CNT)) begin
                            state    <= LOCKED;
                            locked_o <= 1'b1;
                            tok_cnt  <= '0;
                        end else begin
                            tok_cnt <= cnt_next[7:0];
                        end
                    end else if (timer_done) begin
                        offset_o <= next_offset(offset_o);
                        timer    <= '0;
                        tok_cnt  <= '0;
                    end else begin
                        timer   <= timer + TW'(1);
                        tok_cnt <= '0;
                    end
                end
                LOCKED: begin
                    if (is_tok) begin
                        timer <= '0;
                    end else if (timer_done) begin
                        state    <= SEARCH;
                        locked_o <= 1'b0;
                        offset_o <= next_offset(offset_o);
                        timer    <= '0;
                        tok_cnt  <= '0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: state <= SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Scoreboard bench for tmds_word_aligner: a serial bit stream is chopped into
// words, a bit-level reference model predicts every output word.
module tb_tmds_word_aligner;

    localparam int LOCK_CNT = 8;
    localparam int TIMEOUT  = 16;

    logic       ref_clk_i = 1'b0;
    logic       rst       = 1'b1;
    logic [9:0] raw_i     = '0;
    logic [9:0] dat_o;
    logic       tok_o;
    logic [1:0] ctl_o;
    logic       locked_o;
    logic [3:0] offset_o;

    tmds_word_aligner #(
        .LOCK_CNT (LOCK_CNT),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .ref_clk_i (ref_clk_i),
        .rst       (rst),
        .raw_i     (raw_i),
        .dat_o     (dat_o),
        .tok_o     (tok_o),
        .ctl_o     (ctl_o),
        .locked_o  (locked_o),
        .offset_o  (offset_o)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    typedef struct {
        logic [9:0] dat;
        logic       tok;
        logic [1:0] ctl;
        logic       locked;
        logic [3:0] offset;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Reference model: the line as a serial bit stream.
    logic [9:0] tokens [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
    bit         bitq[$];   // bits still to be sent, earliest first
    bit         hist[$];   // last 20 received bits, earliest first
    int         m_off, m_run, m_quiet;
    bit         m_locked;
    logic [1:0] m_ctl;

    task automatic model_reset();
        hist.delete();
        repeat (20) hist.push_back(1'b0);
        m_off    = 0;
        m_run    = 0;
        m_quiet  = 0;
        m_locked = 1'b0;
        m_ctl    = 2'b00;
    endtask

    task automatic push_word(input logic [9:0] v);
        for (int i = 0; i < 10; i++) bitq.push_back(v[i]);
    endtask

    task automatic push_bits(input int n, input bit random_bits);
        for (int i = 0; i < n; i++) bitq.push_back(random_bits ? 1'($urandom) : 1'b0);
    endtask

    // Send one word on the next falling edge and predict what the DUT shows
    // after the following rising edge.
    task automatic step();
        logic [9:0] word;
        logic [9:0] win;
        int         code;
        exp_t       e;
        @(negedge ref_clk_i);
        for (int i = 0; i < 10; i++) begin
            if (bitq.size() > 0) word[i] = bitq.pop_front();
            else                 word[i] = 1'b0;
        end
        raw_i = word;
        for (int i = 0; i < 10; i++) begin
            hist.push_back(word[i]);
            hist.delete(0);
        end
        for (int i = 0; i < 10; i++) win[i] = hist[m_off + i];
        code = -1;
        for (int t = 0; t < 4; t++) if (win == tokens[t]) code = t;
        e.dat = win;
        e.tok = (code >= 0);
        if (code >= 0) m_ctl = 2'(code);
        e.ctl = m_ctl;
        if (code >= 0) begin
            m_quiet = 0;
            if (!m_locked) begin
                m_run++;
                if (m_run == LOCK_CNT) begin
                    m_locked = 1'b1;
                    m_run    = 0;
                end
            end
        end else begin
            m_run = 0;
            m_quiet++;
            if (m_quiet == TIMEOUT) begin
                m_locked = 1'b0;
                m_off    = (m_off + 1) % 10;
                m_quiet  = 0;
            end
        end
        e.locked = m_locked;
        e.offset = 4'(m_off);
        exp_q.push_back(e);
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    // Sample just after the rising edge that consumed the last driven word.
    task automatic settle();
        @(posedge ref_clk_i);
        #2;
    endtask

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        raw_i = '0;
        bitq.delete();
        exp_q.delete();
        model_reset();
        repeat (2) @(posedge ref_clk_i);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: compare every output word against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(posedge ref_clk_i);
            #1;
            if (!rst && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (dat_o !== e.dat || tok_o !== e.tok || ctl_o !== e.ctl ||
                    locked_o !== e.locked || offset_o !== e.offset) begin
                    n_bad++;
                    $display("FAIL word @%0t: got dat=%h tok=%b ctl=%b locked=%b off=%0d, expected dat=%h tok=%b ctl=%b locked=%b off=%0d",
                             $time, dat_o, tok_o, ctl_o, locked_o, offset_o,
                             e.dat, e.tok, e.ctl, e.locked, e.offset);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #12;
        check("reset dat", dat_o, 10'h000);
        check("reset tok", {9'd0, tok_o}, 10'd0);
        check("reset locked", {9'd0, locked_o}, 10'd0);
        check("reset offset", {6'd0, offset_o}, 10'd0);

        // Aligned stream of CTL0 tokens.
        apply_reset();
        repeat (20) push_word(10'h354);
        steps(20);
        settle();
        check("aligned locked", {9'd0, locked_o}, 10'd1);
        check("aligned offset", {6'd0, offset_o}, 10'd0);
        check("aligned dat", dat_o, 10'h354);
        check("aligned ctl", {8'd0, ctl_o}, 10'd0);
        check("aligned tok", {9'd0, tok_o}, 10'd1);

        // Same stream three bits late: hunt up to offset 3.
        apply_reset();
        push_bits(3, 1'b0);
        repeat (80) push_word(10'h354);
        steps(62);
        settle();
        check("delay3 locked", {9'd0, locked_o}, 10'd1);
        check("delay3 offset", {6'd0, offset_o}, 10'd3);
        check("delay3 dat", dat_o, 10'h354);

        // Lose the tokens, then resume with another token type 7 bits late.
        bitq.delete();
        repeat (30) push_word(10'($urandom));
        push_bits(7, 1'b1);
        repeat (300) push_word(10'h2AB);
        steps(330);
        settle();
        check("relock locked", {9'd0, locked_o}, 10'd1);
        check("relock offset", {6'd0, offset_o}, 10'd7);
        check("relock ctl", {8'd0, ctl_o}, 10'd3);

        // Seven tokens, one break, then tokens: the run count restarts.
        apply_reset();
        repeat (7) push_word(10'h0AB);
        push_word(10'h000);
        repeat (20) push_word(10'h0AB);
        steps(16);
        settle();
        check("break not locked", {9'd0, locked_o}, 10'd0);
        step();
        settle();
        check("break locked", {9'd0, locked_o}, 10'd1);
        check("break offset", {6'd0, offset_o}, 10'd0);

        // Token exactly on the expiring timer while searching.
        apply_reset();
        repeat (14) push_word(10'h000);
        push_word(10'h154);
        repeat (20) push_word(10'h000);
        steps(18);
        settle();
        check("search expiry offset", {6'd0, offset_o}, 10'd0);

        // Token exactly on the expiring timer while locked, then real loss.
        apply_reset();
        repeat (10) push_word(10'h354);
        repeat (15) push_word(10'h000);
        push_word(10'h354);
        repeat (20) push_word(10'h000);
        steps(27);
        settle();
        check("locked expiry kept", {9'd0, locked_o}, 10'd1);
        steps(15);
        settle();
        check("locked before drop", {9'd0, locked_o}, 10'd1);
        step();
        settle();
        check("locked dropped", {9'd0, locked_o}, 10'd0);
        check("drop offset", {6'd0, offset_o}, 10'd1);

        // Asynchronous reset mid-search at offset 5 with a partial token run.
        apply_reset();
        push_bits(805, 1'b0);
        repeat (20) push_word(10'h354);
        steps(85);
        settle();
        check("pre-reset offset", {6'd0, offset_o}, 10'd5);
        #1;
        rst = 1'b1;
        #1;
        check("async rst dat", dat_o, 10'h000);
        check("async rst tok", {9'd0, tok_o}, 10'd0);
        check("async rst ctl", {8'd0, ctl_o}, 10'd0);
        check("async rst locked", {9'd0, locked_o}, 10'd0);
        check("async rst offset", {6'd0, offset_o}, 10'd0);
        apply_reset();

        // Idle line: the offset walks through 9 and wraps to 0.
        push_bits(1600, 1'b0);
        steps(144);
        settle();
        check("walk offset 9", {6'd0, offset_o}, 10'd9);
        steps(16);
        settle();
        check("wrap offset 0", {6'd0, offset_o}, 10'd0);

        // Randomised tail: random words interleaved with token bursts.
        for (int r = 0; r < 20; r++) begin
            if ($urandom_range(0, 1) == 1) begin
                push_bits($urandom_range(0, 9), 1'b1);
                repeat ($urandom_range(4, 12)) push_word(tokens[$urandom_range(0, 3)]);
            end else begin
                repeat ($urandom_range(1, 10)) push_word(10'($urandom));
            end
        end
        while (bitq.size() >= 10) step();
        settle();
        repeat (2) @(posedge ref_clk_i);
        #2;
        if (exp_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d words left unchecked, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
